// File: rtl/input_fifo_array.sv
// Bank of NUM_CH independent synchronous FIFOs sharing one write bus, with an
// optional gang mode that pairs channels (2k, 2k+1) to absorb a wide input word.
module input_fifo_array #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DIN_WIDTH  = 36,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CW        = ADDR_W + 1
) (
  input  logic                         CLK_WR,
  input  logic                         rst_n,
  input  logic [DIN_WIDTH-1:0]         din,
  input  logic [NUM_CH-1:0]            WR_EN,
  input  logic [NUM_CH-1:0]            RD_EN,
  input  logic                         col_en,
  input  logic [NUM_CH-1:0]            reg_en_flag,
  input  logic                         err_clr,
  output logic [NUM_CH*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH*CW-1:0]         count,
  output logic [NUM_CH-1:0]            ovf,
  output logic [NUM_CH-1:0]            udf
);

  localparam int HI_W = DIN_WIDTH - DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // In gang mode an odd channel follows the controls of its even partner.
    localparam int SRC = ((c % 2) == 1) ? c - 1 : c;

    logic                  wr_req_s;
    logic                  rd_req_s;
    logic                  flag_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [DATA_WIDTH-1:0] rd_word_r;
    logic                  ovf_r;
    logic                  udf_r;

    // Effective per-channel request, output-enable and write-word selection.
    always_comb begin
      wr_req_s = WR_EN[c];
      rd_req_s = RD_EN[c];
      flag_s   = reg_en_flag[c];
      wdata_s  = {DATA_WIDTH{1'b0}};
      if (col_en && (SRC != c)) begin
        wr_req_s = WR_EN[SRC];
        rd_req_s = RD_EN[SRC];
        flag_s   = reg_en_flag[SRC];
        wdata_s[HI_W-1:0] = din[DIN_WIDTH-1:DATA_WIDTH];
      end else begin
        wdata_s = din[DATA_WIDTH-1:0];
      end
    end

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {CW{1'b0}});
    // A read on empty is rejected; a write on full only proceeds if a read frees a slot.
    assign rd_acc_s  = rd_req_s & ~empty_s;
    assign wr_acc_s  = wr_req_s & (~full_s | rd_acc_s);
    assign ovf_set_s = wr_req_s & full_s & ~rd_acc_s;
    assign udf_set_s = rd_req_s & empty_s;

    // Storage array, no reset needed since occupancy is tracked by count_r.
    always_ff @(posedge CLK_WR) begin
      if (wr_acc_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
      end
    end

    // Pointers, occupancy, registered head word and sticky error flags.
    always_ff @(posedge CLK_WR or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_r  <= {ADDR_W{1'b0}};
        rd_ptr_r  <= {ADDR_W{1'b0}};
        count_r   <= {CW{1'b0}};
        rd_word_r <= {DATA_WIDTH{1'b0}};
        ovf_r     <= 1'b0;
        udf_r     <= 1'b0;
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
        end
        if (rd_acc_s) begin
          rd_ptr_r  <= rd_ptr_r + ADDR_W'(1);
          rd_word_r <= mem_r[rd_ptr_r];
        end
        case ({wr_acc_s, rd_acc_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
        // A fresh error outranks a simultaneous clear.
        ovf_r <= ovf_set_s | (ovf_r & ~err_clr);
        udf_r <= udf_set_s | (udf_r & ~err_clr);
      end
    end

    assign RD_DATA[c*DATA_WIDTH +: DATA_WIDTH] = rd_word_r & {DATA_WIDTH{flag_s}};
    assign count[c*CW +: CW] = count_r;
    assign full[c]           = full_s;
    assign empty[c]          = empty_s;
    assign almost_full[c]    = (count_r >= AF_C);
    assign ovf[c]            = ovf_r;
    assign udf[c]            = udf_r;
  end

endmodule

// File: tb/tb_input_fifo_array.sv
// Directed self-checking bench for input_fifo_array with default parameters.
module tb_input_fifo_array;

  logic         CLK_WR;
  logic         rst_n;
  logic [35:0]  din;
  logic [3:0]   WR_EN;
  logic [3:0]   RD_EN;
  logic         col_en;
  logic [3:0]   reg_en_flag;
  logic         err_clr;
  logic [127:0] RD_DATA;
  logic [3:0]   full;
  logic [3:0]   empty;
  logic [3:0]   almost_full;
  logic [11:0]  count;
  logic [3:0]   ovf;
  logic [3:0]   udf;

  int n_tests = 0;
  int n_fail  = 0;

  input_fifo_array dut (
    .CLK_WR(CLK_WR), .rst_n(rst_n), .din(din), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .col_en(col_en), .reg_en_flag(reg_en_flag), .err_clr(err_clr),
    .RD_DATA(RD_DATA), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .ovf(ovf), .udf(udf)
  );

  initial CLK_WR = 1'b0;
  always #5 CLK_WR = ~CLK_WR;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK_WR);
    #1;
  endtask

  task automatic idle();
    WR_EN = 4'b0000;
    RD_EN = 4'b0000;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 36'h0; col_en = 1'b0; reg_en_flag = 4'b0000;
    idle();
    #12;
    n_tests++; if (empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty: got %h expected f", empty); end
    n_tests++; if (full !== 4'h0) begin n_fail++; $display("FAIL reset_full: got %h expected 0", full); end
    n_tests++; if (almost_full !== 4'h0) begin n_fail++; $display("FAIL reset_af: got %h expected 0", almost_full); end
    n_tests++; if (count !== 12'h000) begin n_fail++; $display("FAIL reset_count: got %h expected 000", count); end
    n_tests++; if (RD_DATA !== 128'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", RD_DATA); end
    n_tests++; if ({ovf, udf} !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h expected 00", {ovf, udf}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_w [4];
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    reg_en_flag = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      din = {4'h0, exp_w[i]}; WR_EN = 4'b0001;
      tick();
      if (i == 1) begin
        n_tests++; if (almost_full[0] !== 1'b0) begin n_fail++; $display("FAIL af_at_2: got %b expected 0", almost_full[0]); end
      end
      if (i == 2) begin
        n_tests++; if (almost_full[0] !== 1'b1) begin n_fail++; $display("FAIL af_at_3: got %b expected 1", almost_full[0]); end
        n_tests++; if (full[0] !== 1'b0) begin n_fail++; $display("FAIL full_at_3: got %b expected 0", full[0]); end
      end
    end
    idle();
    n_tests++; if (full[0] !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full[0]); end
    n_tests++; if (count[2:0] !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count[2:0]); end
    n_tests++; if (RD_DATA[31:0] !== 32'h0) begin n_fail++; $display("FAIL pre_read_data: got %h expected 0", RD_DATA[31:0]); end
    for (int i = 0; i < 4; i++) begin
      RD_EN = 4'b0001;
      tick();
      n_tests++; if (RD_DATA[31:0] !== exp_w[i]) begin n_fail++; $display("FAIL drain_%0d: got %h expected %h", i, RD_DATA[31:0], exp_w[i]); end
    end
    idle();
    n_tests++; if (empty[0] !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty[0]); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4];
    exp_w = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};
    for (int i = 0; i < 4; i++) begin
      din = 36'hA0 + 36'(i); WR_EN = 4'b0001;
      tick();
    end
    din = 36'hFF; WR_EN = 4'b0001;
    tick();
    n_tests++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf[0]); end
    n_tests++; if (count[2:0] !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count[2:0]); end
    din = 36'hB0; WR_EN = 4'b0001; RD_EN = 4'b0001;
    tick();
    idle();
    n_tests++; if (count[2:0] !== 3'd4) begin n_fail++; $display("FAIL rw_full_count: got %0d expected 4", count[2:0]); end
    n_tests++; if (RD_DATA[31:0] !== 32'hA0) begin n_fail++; $display("FAIL rw_full_data: got %h expected a0", RD_DATA[31:0]); end
    n_tests++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b expected 1", ovf[0]); end
    for (int i = 0; i < 4; i++) begin
      RD_EN = 4'b0001;
      tick();
      n_tests++; if (RD_DATA[31:0] !== exp_w[i]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, RD_DATA[31:0], exp_w[i]); end
    end
    idle();
    err_clr = 1'b1;
    tick();
    idle();
    n_tests++; if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf[0]); end
  endtask

  task automatic test_underflow();
    reg_en_flag = 4'b0010;
    din = 36'h5A; WR_EN = 4'b0010;
    tick();
    idle(); RD_EN = 4'b0010;
    tick();
    n_tests++; if (RD_DATA[63:32] !== 32'h5A) begin n_fail++; $display("FAIL ch1_prime: got %h expected 5a", RD_DATA[63:32]); end
    din = 36'hAB; WR_EN = 4'b0010; RD_EN = 4'b0010;
    tick();
    idle();
    n_tests++; if (udf[1] !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b expected 1", udf[1]); end
    n_tests++; if (count[5:3] !== 3'd1) begin n_fail++; $display("FAIL udf_count: got %0d expected 1", count[5:3]); end
    n_tests++; if (RD_DATA[63:32] !== 32'h5A) begin n_fail++; $display("FAIL udf_hold: got %h expected 5a", RD_DATA[63:32]); end
    RD_EN = 4'b0010;
    tick();
    n_tests++; if (RD_DATA[63:32] !== 32'hAB) begin n_fail++; $display("FAIL udf_word: got %h expected ab", RD_DATA[63:32]); end
    err_clr = 1'b1; RD_EN = 4'b0010;
    tick();
    idle();
    n_tests++; if (udf[1] !== 1'b1) begin n_fail++; $display("FAIL err_priority: got %b expected 1", udf[1]); end
    err_clr = 1'b1;
    tick();
    idle();
    n_tests++; if (udf[1] !== 1'b0) begin n_fail++; $display("FAIL udf_clr: got %b expected 0", udf[1]); end
  endtask

  task automatic test_gang();
    col_en = 1'b1; reg_en_flag = 4'b0001;
    din = 36'h9_DEADBEEF; WR_EN = 4'b0001;
    tick();
    din = 36'h1_11111111; WR_EN = 4'b0010;
    tick();
    idle(); RD_EN = 4'b0010;
    tick();
    idle();
    n_tests++; if (count[5:0] !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL gang_count: got %h expected 09", count[5:0]); end
    n_tests++; if (udf[1] !== 1'b0) begin n_fail++; $display("FAIL gang_rd1_ignored: got %b expected 0", udf[1]); end
    RD_EN = 4'b0001;
    tick();
    idle();
    n_tests++; if (RD_DATA[63:0] !== 64'h00000009_DEADBEEF) begin n_fail++; $display("FAIL gang_read: got %h expected 00000009deadbeef", RD_DATA[63:0]); end
    n_tests++; if (empty[1:0] !== 2'b11) begin n_fail++; $display("FAIL gang_empty: got %b expected 11", empty[1:0]); end
    col_en = 1'b0;
    #1;
    n_tests++; if (RD_DATA[63:32] !== 32'h0) begin n_fail++; $display("FAIL ungang_flag: got %h expected 0", RD_DATA[63:32]); end
  endtask

  task automatic test_reset_mid();
    reg_en_flag = 4'hF;
    for (int i = 0; i < 3; i++) begin
      din = 36'h21 + 36'(i); WR_EN = 4'b0100;
      tick();
    end
    idle();
    n_tests++; if (count[8:6] !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", count[8:6]); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (count[8:6] !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", count[8:6]); end
    n_tests++; if (empty !== 4'hF) begin n_fail++; $display("FAIL mid_reset_empty: got %h expected f", empty); end
    n_tests++; if (RD_DATA !== 128'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 0", RD_DATA); end
    WR_EN = 4'b0100; din = 36'h66;
    tick();
    n_tests++; if (count[8:6] !== 3'd0) begin n_fail++; $display("FAIL reset_no_sample: got %0d expected 0", count[8:6]); end
    idle();
    #1 rst_n = 1'b1;
    tick();
    din = 36'h77; WR_EN = 4'b0100;
    tick();
    idle(); RD_EN = 4'b0100;
    tick();
    idle();
    n_tests++; if (RD_DATA[95:64] !== 32'h77) begin n_fail++; $display("FAIL post_reset_word: got %h expected 77", RD_DATA[95:64]); end
  endtask

  task automatic test_flag_gate();
    reg_en_flag = 4'b0000;
    din = 36'h3C; WR_EN = 4'b1000;
    tick();
    idle(); RD_EN = 4'b1000;
    tick();
    idle();
    n_tests++; if (RD_DATA[127:96] !== 32'h0) begin n_fail++; $display("FAIL flag_off: got %h expected 0", RD_DATA[127:96]); end
    reg_en_flag = 4'b1000;
    #1;
    n_tests++; if (RD_DATA[127:96] !== 32'h3C) begin n_fail++; $display("FAIL flag_on: got %h expected 3c", RD_DATA[127:96]); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_gang();
    test_reset_mid();
    test_flag_gate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
